// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: FSM state encoding,
// the canonical NOP word, RV32I major opcodes and small address helpers.
package fetch_unit_pkg;

   // Fetch FSM states. imem_req is asserted exactly in ST_FETCH and ST_KILL.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // one cycle after reset before the first request
      ST_FETCH = 2'd1,   // request outstanding, data will be used
      ST_HOLD  = 2'd2,   // word parked in the hold buffer, IF/ID stalled
      ST_KILL  = 2'd3    // request outstanding, data will be dropped
   } fetch_state_t;

   // Canonical NOP: addi x0, x0, 0.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Sequential fetch stride in bytes.
   localparam logic [31:0] PC_STEP = 32'd4;

   // RV32I major opcodes (instr[6:0]) consumed by the ID decoder.
   localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
   localparam logic [6:0] OPC_STORE    = 7'b010_0011;
   localparam logic [6:0] OPC_OP       = 7'b011_0011;
   localparam logic [6:0] OPC_LUI      = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
   localparam logic [6:0] OPC_JALR     = 7'b110_0111;
   localparam logic [6:0] OPC_JAL      = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

   // Force an address onto a word boundary; redirect targets may carry
   // stray low bits from the ALU.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer for the fetch stage. It parks a returned word and
// its address when the IF/ID register is full and the decoder is stalled.
module fetch_hold_buf
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_load,    // capture i_data / i_pc, mark full
   input  logic        i_clear,   // drop contents (flush or drain); wins over load
   input  logic [31:0] i_data,
   input  logic [31:0] i_pc,
   output logic [31:0] o_data,
   output logic [31:0] o_pc,
   output logic        o_full
);

   logic [31:0] r_data;
   logic [31:0] r_pc;
   logic        r_full;

   // Capture or drop the parked word; a flush must never leave it valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the data/pc fields are reset too (to a harmless NOP) even
         // though only r_full is architecturally needed; a single entry is
         // cheap and it keeps X out of the IF/ID path in simulation.
         r_data <= NOP_INSTR;
         r_pc   <= '0;
         r_full <= 1'b0;
      end else if (i_clear) begin
         r_full <= 1'b0;
      end else if (i_load) begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_data <= i_data;
         r_pc   <= i_pc;
         r_full <= 1'b1;
      end
   end

   assign o_data = r_data;
   assign o_pc   = r_pc;
   assign o_full = r_full;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Issues one word-aligned read at a time to the
// instruction memory, delivers words in program order into the IF/ID
// register, absorbs one word of decoder back-pressure in a hold buffer and
// flushes on redirects, dropping the data of any request already in flight.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4_out,
   output logic        valid_out
);

   // FSM and address registers
   fetch_state_t r_state;
   logic [31:0]  r_fetch_pc;   // next address fetching should resume from
   logic [31:0]  r_req_addr;   // address of the outstanding request

   // IF/ID register
   logic [31:0]  r_instr;
   logic [31:0]  r_pc;
   logic [31:0]  r_pc4;
   logic         r_valid;

   // Derived values
   logic [31:0]  w_redirect_target;
   logic [31:0]  w_req_next;
   logic         w_consume;
   logic         w_ifid_free;

   // Hold buffer interface
   logic         w_hold_load;
   logic         w_hold_clear;
   logic [31:0]  w_hold_data;
   logic [31:0]  w_hold_pc;
   logic         w_hold_full;

   assign w_redirect_target = word_align(redirect_pc);
   assign w_req_next        = r_req_addr + PC_STEP;   // wraps modulo 2^32
   assign w_consume         = r_valid && !stall;
   assign w_ifid_free       = !r_valid || !stall;

   fetch_hold_buf u_hold_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_hold_load),
      .i_clear (w_hold_clear),
      .i_data  (imem_rdata),
      .i_pc    (r_req_addr),
      .o_data  (w_hold_data),
      .o_pc    (w_hold_pc),
      .o_full  (w_hold_full)
   );

   // Decide when the hold buffer parks a word and when it is emptied.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case leaves it unassigned (which would infer a latch).
      w_hold_load  = 1'b0;
      w_hold_clear = 1'b0;
      if (redirect_valid) begin
         w_hold_clear = 1'b1;
      end else begin
         case (r_state)
            ST_FETCH: w_hold_load  = imem_ready && !w_ifid_free;
            ST_HOLD:  w_hold_clear = !stall;
            default:  ;
         endcase
      end
   end

   // Fetch FSM together with the address and IF/ID registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_instr    <= '0;
         r_pc       <= '0;
         r_pc4      <= '0;
         r_valid    <= 1'b0;
      end else begin
         // ID took the current instruction; later assignments reload it.
         if (w_consume) begin
            r_valid <= 1'b0;
         end

         if (redirect_valid) begin
            // Redirect outranks stall and imem_ready: flush and refetch.
            r_valid    <= 1'b0;
            r_fetch_pc <= w_redirect_target;
            case (r_state)
               ST_IDLE, ST_HOLD: begin
                  r_req_addr <= w_redirect_target;
                  r_state    <= ST_FETCH;
               end
               ST_FETCH: begin
                  if (imem_ready) begin
                     // Request finishes now; drop its data, reissue at once.
                     r_req_addr <= w_redirect_target;
                     r_state    <= ST_FETCH;
                  end else begin
                     // Keep the old address stable until the memory answers.
                     r_state <= ST_KILL;
                  end
               end
               default: begin
                  // Already killing: only the resume address moves.
                  r_state <= ST_KILL;
               end
            endcase
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_req_addr <= r_fetch_pc;
                  r_state    <= ST_FETCH;
               end

               ST_FETCH: begin
                  if (imem_ready) begin
                     r_fetch_pc <= w_req_next;
                     if (w_ifid_free) begin
                        r_instr    <= imem_rdata;
                        r_pc       <= r_req_addr;
                        r_pc4      <= w_req_next;
                        r_valid    <= 1'b1;
                        r_req_addr <= w_req_next;
                     end else begin
                        // Word parked in the hold buffer this edge.
                        r_state <= ST_HOLD;
                     end
                  end
               end

               ST_HOLD: begin
                  if (!stall) begin
                     if (w_hold_full) begin
                        r_instr <= w_hold_data;
                        r_pc    <= w_hold_pc;
                        r_pc4   <= w_hold_pc + PC_STEP;
                        r_valid <= 1'b1;
                     end
                     r_req_addr <= r_fetch_pc;
                     r_state    <= ST_FETCH;
                  end
               end

               default: begin
                  // ST_KILL: wait out the stale request, then resume.
                  if (imem_ready) begin
                     r_req_addr <= r_fetch_pc;
                     r_state    <= ST_FETCH;
                  end
               end
            endcase
         end
      end
   end

   assign imem_req     = (r_state == ST_FETCH) || (r_state == ST_KILL);
   assign imem_addr    = r_req_addr;
   assign instr_out    = r_instr;
   assign pc_out       = r_pc;
   assign pc_plus4_out = r_pc4;
   assign valid_out    = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios for reset, streaming,
// hold, kill, coincident redirect, address wrap and reset during hold, then
// a randomized run checked against a program-order scoreboard.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;

   // Default instance (RESET_PC = 0)
   logic        stall, redirect_valid, imem_ready;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, valid_out;
   logic [31:0] imem_addr, instr_out, pc_out, pc_plus4_out;

   // Wrap instance (RESET_PC = 0xFFFF_FFFC)
   logic        w_stall, w_redirect_valid, w_imem_ready;
   logic [31:0] w_redirect_pc, w_imem_rdata;
   logic        w_imem_req, w_valid_out;
   logic [31:0] w_imem_addr, w_instr_out, w_pc_out, w_pc_plus4_out;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset_n(reset_n), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr_out(instr_out), .pc_out(pc_out),
      .pc_plus4_out(pc_plus4_out), .valid_out(valid_out)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .stall(w_stall),
      .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_ready(w_imem_ready), .imem_rdata(w_imem_rdata),
      .instr_out(w_instr_out), .pc_out(w_pc_out),
      .pc_plus4_out(w_pc_plus4_out), .valid_out(w_valid_out)
   );

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
   endfunction

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ready = 1'b0; imem_rdata = '0;
      w_stall = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0;
      w_imem_ready = 1'b0; w_imem_rdata = '0;
   endtask

   // Reset both instances; returns just after an edge with reset released.
   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // Stimulus only: stream 0x0 and 0x4, then stall while 0x8 returns.
   task automatic drive_to_hold();
      do_reset();
      tick();
      imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
      tick();
      imem_rdata = mem_word(32'h4);
      tick();
      stall = 1'b1; imem_rdata = mem_word(32'h8);
      tick();
      imem_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tick();
      imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
      tick();
      // Abandon a live request mid-cycle; memory keeps signalling ready.
      #2 reset_n = 1'b0; imem_rdata = 32'hDEAD_BEEF;
      #1;
      n_total++;
      if ({imem_req, valid_out, instr_out, pc_out, pc_plus4_out, imem_addr} !== '0)
         $display("FAIL reset_immediate: req=%b valid=%b instr=%h pc=%h pc4=%h addr=%h, expected all 0",
                  imem_req, valid_out, instr_out, pc_out, pc_plus4_out, imem_addr);
      else n_pass++;
      tick();
      tick();
      n_total++;
      if ({imem_req, valid_out, pc_out} !== '0)
         $display("FAIL reset_held: req=%b valid=%b pc=%h, expected 0", imem_req, valid_out, pc_out);
      else n_pass++;
      reset_n = 1'b1;
      n_total++;
      if (imem_req !== 1'b0) $display("FAIL idle_no_req: req=%b expected 0", imem_req);
      else n_pass++;
      tick();   // ready still high while leaving IDLE: must be ignored
      n_total++;
      if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h0, 1'b0})
         $display("FAIL idle_ignores_ready: req=%b addr=%h valid=%b expected 1/00000000/0",
                  imem_req, imem_addr, valid_out);
      else n_pass++;
      imem_rdata = mem_word(32'h0);
      tick();
      n_total++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h0, mem_word(32'h0)})
         $display("FAIL reset_first_fetch: valid=%b pc=%h instr=%h expected 1/00000000/%h",
                  valid_out, pc_out, instr_out, mem_word(32'h0));
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_stream();
      do_reset();
      tick();
      n_total++;
      if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h0, 1'b0})
         $display("FAIL stream_first_req: req=%b addr=%h valid=%b expected 1/00000000/0",
                  imem_req, imem_addr, valid_out);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a;
         a = 32'(i) * 32'd4;
         imem_ready = 1'b1; imem_rdata = mem_word(a);
         tick();
         n_total++;
         if ({valid_out, pc_out, instr_out, pc_plus4_out, imem_addr} !==
             {1'b1, a, mem_word(a), a + 32'd4, a + 32'd4})
            $display("FAIL stream_%0d: valid=%b pc=%h instr=%h pc4=%h addr=%h expected pc %h",
                     i, valid_out, pc_out, instr_out, pc_plus4_out, imem_addr, a);
         else n_pass++;
      end
      imem_ready = 1'b0;
      tick();
      n_total++;
      if (valid_out !== 1'b0) $display("FAIL stream_drain: valid=%b expected 0", valid_out);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_hold();
      drive_to_hold();
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if ({imem_req, valid_out, pc_out, instr_out, pc_plus4_out} !==
             {1'b0, 1'b1, 32'h4, mem_word(32'h4), 32'h8})
            $display("FAIL hold_frozen_%0d: req=%b valid=%b pc=%h instr=%h pc4=%h expected 0/1/00000004",
                     i, imem_req, valid_out, pc_out, instr_out, pc_plus4_out);
         else n_pass++;
         tick();
      end
      n_total++;
      if ({imem_req, pc_out} !== {1'b0, 32'h4})
         $display("FAIL hold_frozen_2: req=%b pc=%h expected 0/00000004", imem_req, pc_out);
      else n_pass++;
      stall = 1'b0;
      tick();
      n_total++;
      if ({valid_out, pc_out, instr_out, pc_plus4_out, imem_req, imem_addr} !==
          {1'b1, 32'h8, mem_word(32'h8), 32'hC, 1'b1, 32'hC})
         $display("FAIL hold_release: valid=%b pc=%h instr=%h pc4=%h req=%b addr=%h expected pc 8, req C",
                  valid_out, pc_out, instr_out, pc_plus4_out, imem_req, imem_addr);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_kill();
      do_reset();
      tick();
      imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
      tick();
      imem_rdata = mem_word(32'h4);
      tick();
      imem_ready = 1'b0;
      tick();
      tick();
      n_total++;
      if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h8, 1'b0})
         $display("FAIL kill_pending: req=%b addr=%h valid=%b expected 1/00000008/0",
                  imem_req, imem_addr, valid_out);
      else n_pass++;
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h8, 1'b0})
            $display("FAIL kill_hold_addr_%0d: req=%b addr=%h valid=%b expected 1/00000008/0",
                     i, imem_req, imem_addr, valid_out);
         else n_pass++;
         tick();
      end
      imem_ready = 1'b1; imem_rdata = mem_word(32'h8);
      tick();
      imem_ready = 1'b0;
      n_total++;
      if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h100, 1'b0})
         $display("FAIL kill_drop: req=%b addr=%h valid=%b expected 1/00000100/0",
                  imem_req, imem_addr, valid_out);
      else n_pass++;
      tick();
      n_total++;
      if (valid_out !== 1'b0) $display("FAIL kill_wait: valid=%b expected 0", valid_out);
      else n_pass++;
      imem_ready = 1'b1; imem_rdata = mem_word(32'h100);
      tick();
      n_total++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h100, mem_word(32'h100)})
         $display("FAIL kill_target: valid=%b pc=%h instr=%h expected 1/00000100/%h",
                  valid_out, pc_out, instr_out, mem_word(32'h100));
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_redirect_ready();
      do_reset();
      tick();
      imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      tick();
      redirect_valid = 1'b0;
      n_total++;
      if ({valid_out, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200})
         $display("FAIL redir_ready_drop: valid=%b req=%b addr=%h expected 0/1/00000200",
                  valid_out, imem_req, imem_addr);
      else n_pass++;
      imem_rdata = mem_word(32'h200);
      tick();
      n_total++;
      if ({valid_out, pc_out, pc_plus4_out, instr_out} !==
          {1'b1, 32'h200, 32'h204, mem_word(32'h200)})
         $display("FAIL redir_ready_target: valid=%b pc=%h pc4=%h instr=%h expected pc 00000200",
                  valid_out, pc_out, pc_plus4_out, instr_out);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_wrap();
      do_reset();
      tick();
      n_total++;
      if ({w_imem_req, w_imem_addr} !== {1'b1, 32'hFFFF_FFFC})
         $display("FAIL wrap_first_req: req=%b addr=%h expected 1/fffffffc", w_imem_req, w_imem_addr);
      else n_pass++;
      w_imem_ready = 1'b1; w_imem_rdata = mem_word(32'hFFFF_FFFC);
      tick();
      n_total++;
      if ({w_valid_out, w_pc_out, w_pc_plus4_out, w_imem_addr, w_instr_out} !==
          {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC)})
         $display("FAIL wrap_first_instr: valid=%b pc=%h pc4=%h addr=%h instr=%h expected pc4 0 addr 0",
                  w_valid_out, w_pc_out, w_pc_plus4_out, w_imem_addr, w_instr_out);
      else n_pass++;
      w_imem_rdata = mem_word(32'h0);
      tick();
      n_total++;
      if ({w_pc_out, w_pc_plus4_out, w_instr_out} !== {32'h0, 32'h4, mem_word(32'h0)})
         $display("FAIL wrap_second_instr: pc=%h pc4=%h instr=%h expected 00000000/00000004",
                  w_pc_out, w_pc_plus4_out, w_instr_out);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_reset_in_hold();
      drive_to_hold();
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if ({imem_req, valid_out, instr_out, pc_out, pc_plus4_out, imem_addr} !== '0)
         $display("FAIL hold_reset_now: req=%b valid=%b instr=%h pc=%h pc4=%h addr=%h expected all 0",
                  imem_req, valid_out, instr_out, pc_out, pc_plus4_out, imem_addr);
      else n_pass++;
      tick();
      stall = 1'b0;
      reset_n = 1'b1;
      tick();
      n_total++;
      if ({imem_req, imem_addr, valid_out} !== {1'b1, 32'h0, 1'b0})
         $display("FAIL hold_reset_restart: req=%b addr=%h valid=%b expected 1/00000000/0",
                  imem_req, imem_addr, valid_out);
      else n_pass++;
      imem_ready = 1'b1; imem_rdata = mem_word(32'h0);
      tick();
      n_total++;
      if ({valid_out, pc_out, instr_out} !== {1'b1, 32'h0, mem_word(32'h0)})
         $display("FAIL hold_reset_first: valid=%b pc=%h instr=%h expected pc 0",
                  valid_out, pc_out, instr_out);
      else n_pass++;
      clear_inputs();
   endtask

   // Random stall / redirect / memory latency. The scoreboard only knows the
   // architectural rules: instructions reach ID in program order from the
   // last redirect target, carry the memory word for their address, freeze
   // while stalled, vanish after a redirect, and requests stay put until done.
   task automatic test_random(input int n_cycles);
      logic [31:0] exp_pc;
      int          consumed;
      logic        have_prev;
      logic        p_valid, p_stall, p_redir, p_req, p_ready;
      logic [31:0] p_pc, p_instr, p_addr;
      do_reset();
      exp_pc = 32'h0; consumed = 0; have_prev = 1'b0;
      p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0; p_req = 1'b0; p_ready = 1'b0;
      p_pc = '0; p_instr = '0; p_addr = '0;
      for (int c = 0; c < n_cycles; c++) begin
         if (have_prev) begin
            if (p_redir) begin
               n_total++;
               if (valid_out !== 1'b0) $display("FAIL rnd_flush@%0d: valid=%b expected 0", c, valid_out);
               else n_pass++;
            end else if (p_valid && p_stall) begin
               n_total++;
               if ({valid_out, pc_out, instr_out} !== {1'b1, p_pc, p_instr})
                  $display("FAIL rnd_stall_hold@%0d: valid=%b pc=%h instr=%h expected 1/%h/%h",
                           c, valid_out, pc_out, instr_out, p_pc, p_instr);
               else n_pass++;
            end
            if (p_req && !p_ready) begin
               n_total++;
               if ({imem_req, imem_addr} !== {1'b1, p_addr})
                  $display("FAIL rnd_req_stable@%0d: req=%b addr=%h expected 1/%h",
                           c, imem_req, imem_addr, p_addr);
               else n_pass++;
            end
         end
         n_total++;
         if (imem_req === 1'b1 && imem_addr[1:0] !== 2'b00)
            $display("FAIL rnd_align@%0d: addr=%h expected word aligned", c, imem_addr);
         else n_pass++;

         stall          = ($urandom_range(0, 9) < 3);
         redirect_valid = ($urandom_range(0, 39) == 0);
         redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FF);
         imem_ready     = imem_req && ($urandom_range(0, 1) == 1);
         imem_rdata     = imem_ready ? mem_word(imem_addr) : $urandom;

         if (valid_out && !stall) begin
            n_total++;
            if (pc_out !== exp_pc || instr_out !== mem_word(pc_out) || pc_plus4_out !== pc_out + 32'd4)
               $display("FAIL rnd_consume@%0d: pc=%h instr=%h pc4=%h expected pc %h instr %h",
                        c, pc_out, instr_out, pc_plus4_out, exp_pc, mem_word(exp_pc));
            else n_pass++;
            exp_pc = pc_out + 32'd4;
            consumed++;
         end
         if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};

         p_valid = valid_out; p_stall = stall; p_redir = redirect_valid;
         p_req = imem_req; p_ready = imem_ready;
         p_pc = pc_out; p_instr = instr_out; p_addr = imem_addr;
         have_prev = 1'b1;
         tick();
      end
      clear_inputs();
      n_total++;
      if (consumed < n_cycles / 10)
         $display("FAIL rnd_progress: consumed=%0d expected at least %0d", consumed, n_cycles / 10);
      else n_pass++;
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_stream();
      test_hold();
      test_kill();
      test_redirect_ready();
      test_wrap();
      test_reset_in_hold();
      test_random(4000);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 stall  in  1  ID stage cannot accept an instruction this cycle.
REQ-005 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-006 redirect_pc  in  32  redirect target address.
REQ-007 imem_req  out  1  instruction memory read request.
REQ-008 imem_addr  out  32  read address; word aligned.
REQ-009 imem_ready  in  1  imem_rdata valid this cycle; completes the request.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 instr_out  out  32  IF/ID instruction, fed to ID decode (opcode/funct3/funct7 fields).
REQ-012 pc_out  out  32  address of instr_out.
REQ-013 pc_plus4_out  out  32  pc_out + 4, for link-register writeback.
REQ-014 valid_out  out  1  IF/ID register holds a live instruction.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, HOLD, and KILL; imem_req SHALL be 1 exactly in FETCH and KILL.
REQ-016 imem_addr SHALL be driven from a req_addr register that is held constant from assertion of imem_req until imem_ready.
REQ-017 At most one request SHALL be outstanding; imem_ready SHALL be sampled only while imem_req=1.
REQ-018 IDLE SHALL go to FETCH after one cycle, with req_addr=fetch_pc.
REQ-019 An instruction SHALL be consumed at any edge where valid_out=1 and stall=0.
REQ-020 FETCH with imem_ready=1, no redirect, and IF/ID free (valid_out=0 or stall=0): load instr_out=imem_rdata, pc_out=req_addr, pc_plus4_out=req_addr+4, set valid_out=1, set fetch_pc and req_addr to req_addr+4, and stay in FETCH; back-to-back throughput SHALL be one instruction per memory completion.
REQ-021 FETCH with imem_ready=1 and valid_out=1 and stall=1: capture the word and address into a one-entry hold buffer, set fetch_pc=req_addr+4, and go to HOLD.
REQ-022 HOLD: imem_req=0; when stall=0, move the hold buffer to IF/ID (valid_out=1), load req_addr=fetch_pc, and go to FETCH.
REQ-023 When consumption occurs and no new word is loaded, valid_out SHALL clear on the next edge; while stall=1, IF/ID outputs SHALL hold.
REQ-024 redirect_valid SHALL take priority over stall and imem_ready, and on the next edge it SHALL clear valid_out and the hold buffer and set fetch_pc={redirect_pc[31:2],2'b00}.
REQ-025 Redirect in FETCH without imem_ready SHALL go to KILL; the old req_addr SHALL be kept.
REQ-026 Redirect in FETCH coincident with imem_ready SHALL discard imem_rdata, set req_addr to the redirect target, and stay in FETCH.
REQ-027 Redirect in IDLE or HOLD SHALL go to FETCH with req_addr set to the redirect target.
REQ-028 KILL: on imem_ready, discard the data, set req_addr=fetch_pc, and go to FETCH.
REQ-029 A further redirect while in KILL SHALL update fetch_pc only, and the FSM SHALL stay in KILL.
REQ-030 Address arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-031 reset_n=0 SHALL immediately force state=IDLE, fetch_pc=req_addr=RESET_PC, hold buffer empty, valid_out=0, and instr_out=pc_out=pc_plus4_out=0; imem_req SHALL be 0 during reset.
REQ-032 Reset asserted mid-request SHALL abandon the request, and any imem_ready seen while in IDLE SHALL be ignored.

Structure
REQ-033 The state encoding and the NOP constant 32'h0000_0013 SHALL live in the shared constants file alongside the opcode encodings.
REQ-034 The hold buffer SHALL be a sub-module fetch_hold_buf (data, pc, full flag).

Verification
REQ-035 Reset release, memory ready 1 cycle after each request -> addresses 0x0, 0x4, 0x8 fetched; pc_out sequence 0,4,8; valid_out=1 each completion.
REQ-036 stall=1 while IF/ID holds pc 0x4 and word for 0x8 returns -> FSM in HOLD, imem_req=0, outputs frozen; stall=0 -> pc_out 0x8 the next cycle, then request 0xC.
REQ-037 redirect_valid with redirect_pc=0x100 while request 0x8 is pending for 3 cycles -> FSM in KILL, imem_addr stays 0x8, data dropped, then request 0x100; valid_out=0 until 0x100 returns.
REQ-038 redirect_pc=0x203 coincident with imem_ready -> data dropped; next imem_addr=0x200.
REQ-039 RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0; pc_plus4_out=0x0 for the first instruction.
REQ-040 reset_n pulsed low while in HOLD -> all outputs 0 at once; after release, fetching restarts at RESET_PC.
